dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Cache controller sitting directly upstream of the 2-way data cache.
- Accepts single-word CPU load/store requests and drives the cache's lookup, write, fill and deload strobes (cc_* signals).
- Fetches read-miss data from the memory bus and writes stores through to memory.
- Policy: write-through, read-allocate, write-no-allocate; one outstanding request.

Parameters:
ADR_LENGTH, 32, address width
DATA_LENGTH, 32, data word width
CNT_WIDTH, 16, width of hit/miss statistics counters
TIMEOUT_CYCLES, 255, memory wait limit (used only with optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
cpu_req_i  in  1  request strobe, sampled only when cpu_busy_o=0
cpu_we_i  in  1  1=store, 0=load
cpu_adr_i  in  ADR_LENGTH  request address
cpu_dat_i  in  DATA_LENGTH  store data
cpu_dat_o  out  DATA_LENGTH  load data, valid with cpu_ack_o
cpu_ack_o  out  1  one-cycle completion pulse
cpu_busy_o  out  1  request in progress
cpu_err_o  out  1  memory timeout flag, valid with cpu_ack_o
cc_req_o  out  1  one-cycle cache operation strobe
cc_we_o  out  1  cache write (store update or fill)
cc_deload_o  out  1  cache evict-LRU-way request
cc_adr_o  out  ADR_LENGTH  cache address
cc_dat_o  out  DATA_LENGTH  cache write data
cache_dat_i  in  DATA_LENGTH  cache read data
cache_hit_i  in  1  cache hit
cache_free_i  in  1  free way exists at indexed set
mem_req_o  out  1  memory request, held until ack
mem_we_o  out  1  memory write
mem_adr_o  out  ADR_LENGTH  memory address
mem_dat_o  out  DATA_LENGTH  memory write data
mem_dat_i  in  DATA_LENGTH  memory read data
mem_ack_i  in  1  memory completion, one cycle
hit_cnt_o  out  CNT_WIDTH  saturating hit count
miss_cnt_o  out  CNT_WIDTH  saturating miss count

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0, including both counters; latched address/data/we cleared. Reset mid-operation abandons any cache or memory transaction. A mem_ack_i arriving after reset release is ignored.
- States: IDLE, LOOKUP, CHECK, EVICT, MEM_RD, FILL, UPDATE, MEM_WR, RESP.
- IDLE: on cpu_req_i=1, latch cpu_adr_i/cpu_dat_i/cpu_we_i -> LOOKUP. cpu_busy_o=1 in every state except IDLE. cpu_req_i while busy is ignored, not queued.
- LOOKUP: cc_req_o=1, cc_we_o=0, cc_deload_o=0, cc_adr_o=latched address -> CHECK. cc_adr_o and mem_adr_o hold the latched address from LOOKUP through RESP.
- CHECK: sample cache_hit_i, cache_free_i, cache_dat_i.
  - Load hit: hit_cnt++, cpu_dat_o<=cache_dat_i -> RESP.
  - Load miss: miss_cnt++; -> MEM_RD if cache_free_i=1, else -> EVICT.
  - Store hit: hit_cnt++ -> UPDATE.
  - Store miss: miss_cnt++ -> MEM_WR.
- EVICT: cc_req_o=1, cc_deload_o=1, cc_we_o=0 for one cycle -> MEM_RD.
- MEM_RD: mem_req_o=1, mem_we_o=0 until the cycle mem_ack_i=1. Ack may arrive in the first MEM_RD cycle (zero wait). Capture mem_dat_i into the fill register -> FILL. mem_req_o deasserts the cycle after the ack.
- FILL: cc_req_o=1, cc_we_o=1, cc_dat_o=fill data; cpu_dat_o<=fill data -> RESP.
- UPDATE: cc_req_o=1, cc_we_o=1, cc_dat_o=latched store data -> MEM_WR.
- MEM_WR: mem_req_o=1, mem_we_o=1, mem_dat_o=store data until mem_ack_i -> RESP.
- RESP: cpu_ack_o=1 for exactly one cycle -> IDLE. A new request is accepted in the following IDLE cycle at the earliest.
- cc_req_o is never high two consecutive cycles. cc_deload_o and cc_we_o are never both high. mem_ack_i outside MEM_RD/MEM_WR is ignored.
- Latency from request-accept edge to cpu_ack_o:
  - Load hit: 3 cycles.
  - Load miss with free way: 5 + memory wait cycles.
  - Load miss with eviction: 6 + memory wait cycles.
  - Store: 4 (miss) or 5 (hit) + memory wait cycles.
- Counters saturate at all-ones and never wrap. Each counter updates only in CHECK.
- cpu_dat_o holds its value until the next load completes.

Optional Feature:
- Macro: DCACHE_CTRL_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to MEM_RD/MEM_WR and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop mem_req_o; for loads skip FILL and return cpu_dat_o=0; go to RESP with cpu_err_o=1 alongside cpu_ack_o.
  - An ack arriving in the same cycle the limit is reached wins (normal completion, cpu_err_o=0).
- Not defined: the controller waits indefinitely and cpu_err_o is tied 0.

Test Plan:
- Reset mid-MEM_RD (rst low 1 cycle) -> all outputs 0 next cycle; late mem_ack_i ignored; state IDLE.
- Load 0x00001040, cache_hit_i=1, cache_dat_i=0xDEADBEEF -> cpu_ack_o on 3rd cycle, cpu_dat_o=0xDEADBEEF, hit_cnt_o=1, no mem_req_o.
- Load miss, cache_free_i=0, mem ack after 2 waits with 0x12345678 -> one deload pulse, then one fill pulse with cc_dat_o=0x12345678; cpu_dat_o=0x12345678; ack at cycle 8.
- Store hit 0xA5A5A5A5 -> UPDATE pulse (cc_we_o=1), mem_we_o=1, mem_dat_o=0xA5A5A5A5; store miss -> no cc_we_o pulse; miss_cnt_o increments.
- CNT_WIDTH=2, five load hits -> hit_cnt_o saturates at 3.
- With DCACHE_CTRL_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req_o drops after 4 cycles; cpu_ack_o=1, cpu_err_o=1, cpu_dat_o=0, no fill pulse.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// Bundle of the CPU, cache and memory-bus signals around dcache_ctrl.
// master: the controller; slave: the CPU/cache/memory environment.
interface dcache_ctrl_if #(
  parameter int ADR_LENGTH  = 32,
  parameter int DATA_LENGTH = 32,
  parameter int CNT_WIDTH   = 16
);
  logic                   cpu_req_i;
  logic                   cpu_we_i;
  logic [ADR_LENGTH-1:0]  cpu_adr_i;
  logic [DATA_LENGTH-1:0] cpu_dat_i;
  logic [DATA_LENGTH-1:0] cpu_dat_o;
  logic                   cpu_ack_o;
  logic                   cpu_busy_o;
  logic                   cpu_err_o;

  logic                   cc_req_o;
  logic                   cc_we_o;
  logic                   cc_deload_o;
  logic [ADR_LENGTH-1:0]  cc_adr_o;
  logic [DATA_LENGTH-1:0] cc_dat_o;
  logic [DATA_LENGTH-1:0] cache_dat_i;
  logic                   cache_hit_i;
  logic                   cache_free_i;

  logic                   mem_req_o;
  logic                   mem_we_o;
  logic [ADR_LENGTH-1:0]  mem_adr_o;
  logic [DATA_LENGTH-1:0] mem_dat_o;
  logic [DATA_LENGTH-1:0] mem_dat_i;
  logic                   mem_ack_i;

  logic [CNT_WIDTH-1:0]   hit_cnt_o;
  logic [CNT_WIDTH-1:0]   miss_cnt_o;

  modport master (
    input  cpu_req_i, cpu_we_i, cpu_adr_i, cpu_dat_i,
    input  cache_dat_i, cache_hit_i, cache_free_i,
    input  mem_dat_i, mem_ack_i,
    output cpu_dat_o, cpu_ack_o, cpu_busy_o, cpu_err_o,
    output cc_req_o, cc_we_o, cc_deload_o, cc_adr_o, cc_dat_o,
    output mem_req_o, mem_we_o, mem_adr_o, mem_dat_o,
    output hit_cnt_o, miss_cnt_o
  );

  modport slave (
    output cpu_req_i, cpu_we_i, cpu_adr_i, cpu_dat_i,
    output cache_dat_i, cache_hit_i, cache_free_i,
    output mem_dat_i, mem_ack_i,
    input  cpu_dat_o, cpu_ack_o, cpu_busy_o, cpu_err_o,
    input  cc_req_o, cc_we_o, cc_deload_o, cc_adr_o, cc_dat_o,
    input  mem_req_o, mem_we_o, mem_adr_o, mem_dat_o,
    input  hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Write-through, read-allocate, write-no-allocate controller in front of the 2-way data cache.
// Define DCACHE_CTRL_MEM_TIMEOUT_EN to bound memory waits to TIMEOUT_CYCLES (cpu_err_o on expiry).
//
// state  | meaning
// IDLE   | waiting for a CPU request
// LOOKUP | cache lookup strobe issued
// CHECK  | hit/free/data sampled, counters updated
// EVICT  | deload strobe to free the LRU way
// MEM_RD | memory read outstanding
// FILL   | fill strobe writes memory data into the cache
// UPDATE | store-hit write into the cache
// MEM_WR | memory write outstanding
// RESP   | one-cycle CPU acknowledge
module dcache_ctrl #(
  parameter int ADR_LENGTH     = 32,
  parameter int DATA_LENGTH    = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst,
  dcache_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, LOOKUP, CHECK, EVICT, MEM_RD, FILL, UPDATE, MEM_WR, RESP
  } state_t;

  state_t                 state;
  logic [ADR_LENGTH-1:0]  adr_q;
  logic [DATA_LENGTH-1:0] dat_q;
  logic                   we_q;
  logic [DATA_LENGTH-1:0] fill_q;

  logic [DATA_LENGTH-1:0] cpu_dat;
  logic                   cpu_ack;
  logic                   cpu_busy;
  logic                   cpu_err;
  logic                   cc_req;
  logic                   cc_we;
  logic                   cc_deload;
  logic [DATA_LENGTH-1:0] cc_dat;
  logic                   mem_req;
  logic                   mem_we;
  logic [CNT_WIDTH-1:0]   hit_cnt;
  logic [CNT_WIDTH-1:0]   miss_cnt;

  logic                   timed_out;

`ifdef DCACHE_CTRL_MEM_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [WAIT_W-1:0] wait_cnt;

  // Cleared outside the memory states, so every MEM_RD/MEM_WR entry starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if ((state == MEM_RD || state == MEM_WR) && !bus.mem_ack_i) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      fill_q    <= '0;
      cpu_dat   <= '0;
      cpu_ack   <= 1'b0;
      cpu_busy  <= 1'b0;
      cpu_err   <= 1'b0;
      cc_req    <= 1'b0;
      cc_we     <= 1'b0;
      cc_deload <= 1'b0;
      cc_dat    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      cc_req    <= 1'b0;
      cc_we     <= 1'b0;
      cc_deload <= 1'b0;
      cpu_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req_i) begin
            adr_q    <= bus.cpu_adr_i;
            dat_q    <= bus.cpu_dat_i;
            we_q     <= bus.cpu_we_i;
            cpu_busy <= 1'b1;
            cc_req   <= 1'b1;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          state <= CHECK;
        end
        CHECK: begin
          if (bus.cache_hit_i) begin
            if (hit_cnt != {CNT_WIDTH{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
          end else begin
            if (miss_cnt != {CNT_WIDTH{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
          end
          if (!we_q) begin
            if (bus.cache_hit_i) begin
              cpu_dat <= bus.cache_dat_i;
              cpu_ack <= 1'b1;
              state   <= RESP;
            end else if (bus.cache_free_i) begin
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              state   <= MEM_RD;
            end else begin
              cc_req    <= 1'b1;
              cc_deload <= 1'b1;
              state     <= EVICT;
            end
          end else begin
            if (bus.cache_hit_i) begin
              cc_req <= 1'b1;
              cc_we  <= 1'b1;
              cc_dat <= dat_q;
              state  <= UPDATE;
            end else begin
              mem_req <= 1'b1;
              mem_we  <= 1'b1;
              state   <= MEM_WR;
            end
          end
        end
        EVICT: begin
          mem_req <= 1'b1;
          mem_we  <= 1'b0;
          state   <= MEM_RD;
        end
        MEM_RD: begin
          // An ack in the limit cycle takes priority over the timeout.
          if (bus.mem_ack_i) begin
            mem_req <= 1'b0;
            fill_q  <= bus.mem_dat_i;
            cc_req  <= 1'b1;
            cc_we   <= 1'b1;
            cc_dat  <= bus.mem_dat_i;
            state   <= FILL;
          end else if (timed_out) begin
            mem_req <= 1'b0;
            cpu_dat <= '0;
            cpu_err <= 1'b1;
            cpu_ack <= 1'b1;
            state   <= RESP;
          end
        end
        FILL: begin
          cpu_dat <= fill_q;
          cpu_ack <= 1'b1;
          state   <= RESP;
        end
        UPDATE: begin
          mem_req <= 1'b1;
          mem_we  <= 1'b1;
          state   <= MEM_WR;
        end
        MEM_WR: begin
          if (bus.mem_ack_i || timed_out) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            cpu_err <= !bus.mem_ack_i;
            cpu_ack <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          cpu_busy <= 1'b0;
          cpu_err  <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Latched address and store data feed both buses for the whole transaction.
  assign bus.cpu_dat_o   = cpu_dat;
  assign bus.cpu_ack_o   = cpu_ack;
  assign bus.cpu_busy_o  = cpu_busy;
  assign bus.cpu_err_o   = cpu_err;
  assign bus.cc_req_o    = cc_req;
  assign bus.cc_we_o     = cc_we;
  assign bus.cc_deload_o = cc_deload;
  assign bus.cc_adr_o    = adr_q;
  assign bus.cc_dat_o    = cc_dat;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_adr_o   = adr_q;
  assign bus.mem_dat_o   = dat_q;
  assign bus.hit_cnt_o   = hit_cnt;
  assign bus.miss_cnt_o  = miss_cnt;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed table, randomized transactions against a
// transaction-level model, reset and (when enabled) memory-timeout sequences.
module tb_dcache_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hit_n    = 0;
  int   miss_n   = 0;
  logic [31:0] cur_dat = '0;

  dcache_ctrl_if #(.ADR_LENGTH(32), .DATA_LENGTH(32), .CNT_WIDTH(16)) bus ();
  dcache_ctrl_if #(.ADR_LENGTH(32), .DATA_LENGTH(32), .CNT_WIDTH(2))  bus_sat ();

  assign bus_sat.cpu_req_i    = bus.cpu_req_i;
  assign bus_sat.cpu_we_i     = bus.cpu_we_i;
  assign bus_sat.cpu_adr_i    = bus.cpu_adr_i;
  assign bus_sat.cpu_dat_i    = bus.cpu_dat_i;
  assign bus_sat.cache_dat_i  = bus.cache_dat_i;
  assign bus_sat.cache_hit_i  = bus.cache_hit_i;
  assign bus_sat.cache_free_i = bus.cache_free_i;
  assign bus_sat.mem_dat_i    = bus.mem_dat_i;
  assign bus_sat.mem_ack_i    = bus.mem_ack_i;

  dcache_ctrl #(.ADR_LENGTH(32), .DATA_LENGTH(32), .CNT_WIDTH(16), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dcache_ctrl #(.ADR_LENGTH(32), .DATA_LENGTH(32), .CNT_WIDTH(2), .TIMEOUT_CYCLES(TO)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    bit          hit;
    bit          free;
    logic [31:0] cdat;
    int          w;
    logic [31:0] mdat;
    int          lat;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[8];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  // Cycles from accept edge to the acknowledge cycle, from the documented latencies.
  function automatic int model_lat(input bit we, input bit hit, input bit free, input int w);
    if (!we && hit) return 3;
    if (!we)        return (free ? 5 : 6) + w;
    return (hit ? 5 : 4) + w;
  endfunction

  function automatic bit outs_nonzero();
    return (|bus.cpu_dat_o) | bus.cpu_ack_o | bus.cpu_busy_o | bus.cpu_err_o |
           bus.cc_req_o | bus.cc_we_o | bus.cc_deload_o | (|bus.cc_adr_o) | (|bus.cc_dat_o) |
           bus.mem_req_o | bus.mem_we_o | (|bus.mem_adr_o) | (|bus.mem_dat_o) |
           (|bus.hit_cnt_o) | (|bus.miss_cnt_o) | (|bus_sat.hit_cnt_o) | (|bus_sat.miss_cnt_o);
  endfunction

  task automatic run_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input bit hit, input bit free, input logic [31:0] cdat,
                         input int w, input logic [31:0] mdat,
                         input int exp_lat, input logic [31:0] exp_dat, input bit exp_err);
    int lat, mw, n_lookup, n_deload, n_wr, n_mem, exp_mem;
    bit prev_cc, adr_ok, busy_ok, excl_ok, mwe, got_err, load_miss, exp_deload, exp_wr, uses_mem;
    logic [31:0] wr_dat, mdat_seen, got_dat;
    lat = -1; mw = 0; n_lookup = 0; n_deload = 0; n_wr = 0; n_mem = 0;
    prev_cc = 1'b0; adr_ok = 1'b1; busy_ok = 1'b1; excl_ok = 1'b1; mwe = 1'b0; got_err = 1'b0;
    wr_dat = '0; mdat_seen = '0; got_dat = '0;
    load_miss  = !we && !hit;
    exp_deload = load_miss && !free;
    exp_wr     = (we && hit) || (load_miss && !exp_err);
    uses_mem   = we || load_miss;
    exp_mem    = uses_mem ? (exp_err ? TO : w + 1) : 0;

    bus.cpu_req_i    = 1'b1;
    bus.cpu_we_i     = we;
    bus.cpu_adr_i    = adr;
    bus.cpu_dat_i    = dat;
    bus.cache_hit_i  = hit;
    bus.cache_free_i = free;
    bus.cache_dat_i  = cdat;
    bus.mem_ack_i    = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 300 && lat < 0; c++) begin
      @(negedge clk);
      bus.cpu_req_i = 1'($urandom_range(0, 1));
      bus.cpu_we_i  = 1'($urandom_range(0, 1));
      bus.cpu_adr_i = $urandom();
      bus.cpu_dat_i = $urandom();
      if (bus.cc_req_o) begin
        if (prev_cc) excl_ok = 1'b0;
        if (bus.cc_deload_o && bus.cc_we_o) excl_ok = 1'b0;
        if (bus.cc_deload_o) n_deload++;
        else if (bus.cc_we_o) begin
          n_wr++;
          wr_dat = bus.cc_dat_o;
        end else n_lookup++;
      end
      prev_cc = bus.cc_req_o;
      if (bus.cc_adr_o !== adr || bus.mem_adr_o !== adr) adr_ok = 1'b0;
      if (bus.cpu_busy_o !== 1'b1) busy_ok = 1'b0;
      if (bus.mem_req_o) begin
        if (n_mem == 0) begin
          mwe       = bus.mem_we_o;
          mdat_seen = bus.mem_dat_o;
        end
        n_mem++;
        if (mw == w) begin
          bus.mem_ack_i = 1'b1;
          bus.mem_dat_i = mdat;
        end else begin
          bus.mem_ack_i = 1'b0;
          bus.mem_dat_i = $urandom();
          mw++;
        end
      end else begin
        bus.mem_ack_i = 1'($urandom_range(0, 1));
        bus.mem_dat_i = $urandom();
      end
      if (bus.cpu_ack_o) begin
        lat           = c;
        got_dat       = bus.cpu_dat_o;
        got_err       = bus.cpu_err_o;
        bus.cpu_req_i = 1'b0;
      end
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("cpu_dat", 64'(got_dat), 64'(exp_dat));
    chk("cpu_err", 64'(got_err), 64'(exp_err));
    chk("lookup_pulses", 64'(n_lookup), 64'(1));
    chk("deload_pulses", 64'(n_deload), 64'(exp_deload));
    chk("write_pulses", 64'(n_wr), 64'(exp_wr));
    if (exp_wr) chk("cc_write_data", 64'(wr_dat), 64'(we ? dat : mdat));
    chk("mem_req_cycles", 64'(n_mem), 64'(exp_mem));
    if (uses_mem) chk("mem_we", 64'(mwe), 64'(we));
    if (we) chk("mem_dat", 64'(mdat_seen), 64'(dat));
    chk("addr_held", 64'(adr_ok), 64'(1));
    chk("busy_held", 64'(busy_ok), 64'(1));
    chk("cc_strobe_rules", 64'(excl_ok), 64'(1));
    if (hit) hit_n++;
    else     miss_n++;
    chk("hit_cnt", 64'(bus.hit_cnt_o), 64'(sat(hit_n, 65535)));
    chk("miss_cnt", 64'(bus.miss_cnt_o), 64'(sat(miss_n, 65535)));
    chk("hit_cnt_sat2", 64'(bus_sat.hit_cnt_o), 64'(sat(hit_n, 3)));
    chk("miss_cnt_sat2", 64'(bus_sat.miss_cnt_o), 64'(sat(miss_n, 3)));
    @(negedge clk);
    chk("ack_one_cycle", 64'(bus.cpu_ack_o), 64'(0));
    chk("idle_not_busy", 64'(bus.cpu_busy_o), 64'(0));
    bus.mem_ack_i = 1'b0;
    cur_dat = exp_dat;
  endtask

  initial begin
    bit seen;
    vecs[0] = '{1'b0, 32'h0000_1040, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 0, 32'h0,         3, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 32'h0000_1080, 32'h0,         1'b0, 1'b0, 32'h1111_1111, 2, 32'h1234_5678, 8, 32'h1234_5678};
    vecs[2] = '{1'b1, 32'h0000_2000, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h2222_2222, 1, 32'h0,         6, 32'h1234_5678};
    vecs[3] = '{1'b1, 32'h0000_2004, 32'h5A5A_5A5A, 1'b0, 1'b1, 32'h3333_3333, 0, 32'h0,         4, 32'h1234_5678};
    vecs[4] = '{1'b0, 32'h0000_3000, 32'h0,         1'b0, 1'b1, 32'h4444_4444, 0, 32'hCAFE_F00D, 5, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 32'h0000_3040, 32'h0,         1'b0, 1'b1, 32'h5555_5555, 3, 32'h0BAD_F00D, 8, 32'h0BAD_F00D};
    vecs[6] = '{1'b1, 32'h0000_3080, 32'h0102_0304, 1'b1, 1'b1, 32'h6666_6666, 0, 32'h0,         5, 32'h0BAD_F00D};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b0, 1'b0, 32'h7777_7777, 0, 32'h55AA_55AA, 6, 32'h55AA_55AA};

    rst = 1'b1;
    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_adr_i = '0; bus.cpu_dat_i = '0;
    bus.cache_dat_i = '0; bus.cache_hit_i = 1'b0; bus.cache_free_i = 1'b0;
    bus.mem_dat_i = '0; bus.mem_ack_i = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(outs_nonzero()), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].hit, vecs[i].free, vecs[i].cdat,
              vecs[i].w, vecs[i].mdat, vecs[i].lat, vecs[i].exp_dat, 1'b0);
    end

    for (int i = 0; i < 80; i++) begin
      bit r_we, r_hit, r_free;
      int r_w;
      logic [31:0] r_adr, r_dat, r_cdat, r_mdat, r_exp;
      r_we   = 1'($urandom_range(0, 1));
      r_hit  = 1'($urandom_range(0, 1));
      r_free = 1'($urandom_range(0, 1));
      r_w    = int'($urandom_range(0, 3));
      r_adr  = $urandom();
      r_dat  = $urandom();
      r_cdat = $urandom();
      r_mdat = $urandom();
      r_exp  = r_we ? cur_dat : (r_hit ? r_cdat : r_mdat);
      run_txn(r_we, r_adr, r_dat, r_hit, r_free, r_cdat, r_w, r_mdat,
              model_lat(r_we, r_hit, r_free, r_w), r_exp, 1'b0);
    end

    // Reset while a memory read is outstanding; a late ack must not revive it.
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_adr_i = 32'h0000_5000;
    bus.cache_hit_i = 1'b0; bus.cache_free_i = 1'b1; bus.mem_ack_i = 1'b0;
    @(posedge clk);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      bus.cpu_req_i = 1'b0;
      bus.mem_ack_i = 1'b0;
      if (bus.mem_req_o) seen = 1'b1;
    end
    chk("reached_mem_rd", 64'(seen), 64'(1));
    rst = 1'b0;
    #1;
    chk("async_reset_clear", 64'(outs_nonzero()), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ack_i = 1'b1;
    bus.mem_dat_i = 32'h7777_0000;
    @(negedge clk);
    chk("late_ack_ignored", 64'(outs_nonzero()), 64'(0));
    bus.mem_ack_i = 1'b0;
    hit_n = 0; miss_n = 0; cur_dat = '0;

    for (int i = 0; i < 5; i++) begin
      logic [31:0] d;
      d = 32'hC0DE_0000 + 32'(i);
      run_txn(1'b0, 32'h0000_6000 + 32'(4 * i), 32'h0, 1'b1, 1'b0, d, 0, 32'h0, 3, d, 1'b0);
    end

`ifdef DCACHE_CTRL_MEM_TIMEOUT_EN
    run_txn(1'b0, 32'h0000_7000, 32'h0,         1'b0, 1'b1, 32'h1, 1000, 32'h9999_9999, 3 + TO, 32'h0, 1'b1);
    run_txn(1'b0, 32'h0000_7040, 32'h0,         1'b0, 1'b0, 32'h2, 1000, 32'h9999_9999, 4 + TO, 32'h0, 1'b1);
    run_txn(1'b1, 32'h0000_7080, 32'hFEED_BEEF, 1'b0, 1'b0, 32'h3, 1000, 32'h0,         3 + TO, 32'h0, 1'b1);
    run_txn(1'b0, 32'h0000_70C0, 32'h0,         1'b0, 1'b1, 32'h4, TO - 1, 32'h4242_4242,
            5 + TO - 1, 32'h4242_4242, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
